// File: rtl/arith_pkg.sv
// Types and defaults shared by the sequential multiplier and divider datapath blocks.
// Operands are unsigned Q(W-F).F fixed point.
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth    = 10;
  localparam int unsigned DefaultFracBits = 5;
  localparam int unsigned DefaultCntW     = 4;

  // 1.0 in the default fixed-point format.
  localparam logic [DefaultWidth-1:0] One = DefaultWidth'(1) << DefaultFracBits;

endpackage

// File: rtl/step_counter.sv
// Iteration counter shared by the multiplier and divider.
// co_o flags the enabled step in which the count equals the terminal value.
module step_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [CntW-1:0] tc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            co_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign co_o  = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential shift-add unsigned fixed-point multiplier: one multiplier bit per clock,
// result truncated to the operand format and saturated on overflow.
module fixed_point_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned Width    = DefaultWidth,
  parameter int unsigned FracBits = DefaultFracBits,
  parameter int unsigned CntW     = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_a_i,
  input  logic             ld_b_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] p_o,
  output logic             ov_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             co_cnt_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_e             state_q, state_d;
  logic [Width-1:0]   a_q, a_d;
  logic [Width-1:0]   b_q, b_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] addend;
  logic [Width-1:0]   p_q, p_d;
  logic               ov_q, ov_d;

  logic [CntW-1:0]    cnt;
  logic               cnt_clr, cnt_en, cnt_co;

  step_counter #(
    .CntW (CntW)
  ) u_step_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_i   (LastCnt),
    .cnt_o  (cnt),
    .co_o   (cnt_co)
  );

  // a_q is frozen outside IDLE, so it doubles as the working multiplicand.
  assign addend = {{Width{1'b0}}, a_q} << cnt;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    ov_d     = ov_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ld_a_i) a_d = a_i;
        if (ld_b_i) b_d = b_i;
        if (start_i) begin
          mplier_d = ld_b_i ? b_i : b_q;
          acc_d    = '0;
          cnt_clr  = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        cnt_en   = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + addend;
        mplier_d = mplier_q >> 1;
        if (cnt_co) begin
          ov_d    = |acc_d[2*Width-1:FracBits+Width];
          p_d     = ov_d ? '1 : acc_d[FracBits+Width-1:FracBits];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      ov_q     <= ov_d;
    end
  end

  assign p_o      = p_q;
  assign ov_o     = ov_q;
  assign busy_o   = (state_q == StRun);
  assign done_o   = (state_q == StDone);
  assign co_cnt_o = cnt_co;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier against a plain-arithmetic product model.
module tb_fixed_point_multiplier;

  localparam int W = 10;
  localparam int F = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ld_a, ld_b, start;
  logic [W-1:0] a, b;
  logic [W-1:0] p;
  logic         ov, busy, done, co;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixed_point_multiplier dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .ld_a_i   (ld_a),
    .ld_b_i   (ld_b),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .p_o      (p),
    .ov_o     (ov),
    .busy_o   (busy),
    .done_o   (done),
    .co_cnt_o (co)
  );

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] pe, output logic ove);
    longint unsigned prod;
    prod = 64'(x) * 64'(y);
    ove  = (prod >> (W + F)) != 0;
    pe   = ove ? {W{1'b1}} : W'(prod >> F);
  endfunction

  // Drives one start edge; returns just after that edge.
  task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic la, input logic lb);
    @(negedge clk);
    a = xa; b = xb; ld_a = la; ld_b = lb; start = 1'b1;
    @(posedge clk);
    #1;
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
  endtask

  // Samples n cycles after a start edge (k=0 is the cycle just after it).
  task automatic observe(input int n, input int poke_k,
                         output int done_k, output int done_n, output int co_k,
                         output int co_n, output int busy_n,
                         output logic [W-1:0] p_done, output logic ov_done);
    done_k = -1; done_n = 0; co_k = -1; co_n = 0; busy_n = 0;
    p_done = 'x; ov_done = 1'bx;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == poke_k) begin
        ld_a = 1'b1; a = 1; start = 1'b1;
      end else if (k == poke_k + 1) begin
        ld_a = 1'b0; start = 1'b0;
      end
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k; p_done = p; ov_done = ov;
        end
      end
      if (co) begin
        co_n++; co_k = k;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_a = 0; ld_b = 0; start = 0; a = '0; b = '0;
    #12;
    total++;
    if ({p, ov, busy, done, co} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got p=%b ov=%b busy=%b done=%b co=%b want all zero",
               p, ov, busy, done, co);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_case(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb);
    int dk, dn, ck, cn, bn;
    logic [W-1:0] pd, pe;
    logic od, oe;
    model(xa, xb, pe, oe);
    launch(xa, xb, 1'b1, 1'b1);
    observe(14, -10, dk, dn, ck, cn, bn, pd, od);
    total++;
    if (dk !== W || dn !== 1) begin
      bad++;
      $display("FAIL %s_done_timing got k=%0d n=%0d want k=%0d n=1", name, dk, dn, W);
    end
    total++;
    if (pd !== pe || od !== oe) begin
      bad++;
      $display("FAIL %s_result got p=%b ov=%b want p=%b ov=%b", name, pd, od, pe, oe);
    end
    total++;
    if (ck !== W - 1 || cn !== 1 || bn !== W) begin
      bad++;
      $display("FAIL %s_co_busy got co_k=%0d co_n=%0d busy_n=%0d want %0d 1 %0d",
               name, ck, cn, bn, W - 1, W);
    end
    total++;
    if (p !== pe || ov !== oe) begin
      bad++;
      $display("FAIL %s_hold got p=%b ov=%b want p=%b ov=%b", name, p, ov, pe, oe);
    end
  endtask

  task automatic test_directed();
    test_case("frac", 10'b0001101110, 10'b0000000011);
    total++;
    if (p !== 10'b0000001010) begin
      bad++;
      $display("FAIL frac_literal got p=%b want 0000001010", p);
    end
    test_case("one", arith_pkg::One, arith_pkg::One);
    test_case("sat", 10'b1111111111, 10'b1111111111);
    total++;
    if (p !== 10'b1111111111 || ov !== 1'b1) begin
      bad++;
      $display("FAIL sat_literal got p=%b ov=%b want 1111111111 1", p, ov);
    end
    test_case("zero", 10'b0000000000, 10'b1000000101);
  endtask

  task automatic test_preloaded();
    logic [W-1:0] xa, xb, pe;
    logic oe;
    int dk, dn, ck, cn, bn;
    logic [W-1:0] pd;
    logic od;
    xa = W'($urandom_range(0, 1023) >> 3);
    xb = W'($urandom_range(0, 1023) >> 2);
    model(xa, xb, pe, oe);
    @(negedge clk);
    a = xa; b = xb; ld_a = 1'b1; ld_b = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
    launch(~xa, ~xb, 1'b0, 1'b0);
    observe(14, -10, dk, dn, ck, cn, bn, pd, od);
    total++;
    if (dk !== W || pd !== pe || od !== oe) begin
      bad++;
      $display("FAIL preloaded got k=%0d p=%b ov=%b want k=%0d p=%b ov=%b",
               dk, pd, od, W, pe, oe);
    end
  endtask

  task automatic test_ignore_mid_run();
    int dk, dn, ck, cn, bn;
    logic [W-1:0] pd;
    logic od;
    launch(10'b0001101110, 10'b0000000011, 1'b1, 1'b1);
    observe(14, 3, dk, dn, ck, cn, bn, pd, od);
    total++;
    if (dk !== W || dn !== 1 || pd !== 10'b0000001010 || od !== 1'b0) begin
      bad++;
      $display("FAIL ignore_mid_run got k=%0d n=%0d p=%b ov=%b want k=%0d n=1 p=0000001010 ov=0",
               dk, dn, pd, od, W);
    end
    // Restart without loads: the mid-run ld_a must not have reached the operand register.
    launch(10'd1, 10'd1, 1'b0, 1'b0);
    observe(14, -10, dk, dn, ck, cn, bn, pd, od);
    total++;
    if (pd !== 10'b0000001010) begin
      bad++;
      $display("FAIL ignore_mid_run_regs got p=%b want 0000001010", pd);
    end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    int dk, dn2, ck, cn, bn;
    logic [W-1:0] pd;
    logic od;
    launch(10'b1010101010, 10'b0101010101, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) @(negedge clk);
    rst_n = 1'b0;
    #2;
    total++;
    if (p !== '0 || ov !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run got p=%b ov=%b busy=%b done=%b want zeros", p, ov, busy, done);
    end
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL reset_no_done got done_pulses=%0d want 0", dn);
    end
    launch(arith_pkg::One, 10'b0001000000, 1'b1, 1'b1);
    observe(14, -10, dk, dn2, ck, cn, bn, pd, od);
    total++;
    if (dk !== W || pd !== 10'b0001000000 || od !== 1'b0) begin
      bad++;
      $display("FAIL reset_recover got k=%0d p=%b ov=%b want k=%0d p=0001000000 ov=0",
               dk, pd, od, W);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa, xb, pe;
    logic oe;
    int dks[$];
    int bad_p;
    xa = W'($urandom_range(0, 1023));
    xb = W'($urandom_range(0, 63));
    model(xa, xb, pe, oe);
    bad_p = 0;
    @(negedge clk);
    a = xa; b = xb; ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (done) begin
        dks.push_back(k);
        if (p !== pe || ov !== oe) bad_p++;
      end
    end
    start = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    // A DONE cycle and an IDLE cycle separate consecutive runs.
    total++;
    if (dks.size() != 3 || dks[0] != W || dks[1] != 2 * W + 2 || dks[2] != 3 * W + 4) begin
      bad++;
      $display("FAIL back_to_back_timing got n=%0d first=%0d want 3 pulses at %0d,%0d,%0d",
               dks.size(), (dks.size() > 0) ? dks[0] : -1, W, 2 * W + 2, 3 * W + 4);
    end
    total++;
    if (bad_p != 0) begin
      bad++;
      $display("FAIL back_to_back_result got %0d wrong results want 0 (p=%b expect %b)",
               bad_p, p, pe);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb, pe, pd;
    logic oe, od;
    int dk, dn, ck, cn, bn;
    for (int i = 0; i < 16; i++) begin
      xa = W'($urandom_range(0, 1023) >> $urandom_range(0, 9));
      xb = W'($urandom_range(0, 1023) >> $urandom_range(0, 9));
      model(xa, xb, pe, oe);
      launch(xa, xb, 1'b1, 1'b1);
      observe(12, -10, dk, dn, ck, cn, bn, pd, od);
      total++;
      if (dk !== W || pd !== pe || od !== oe) begin
        bad++;
        $display("FAIL random_%0d a=%b b=%b got k=%0d p=%b ov=%b want k=%0d p=%b ov=%b",
                 i, xa, xb, dk, pd, od, W, pe, oe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_preloaded();
    test_ignore_mid_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
